// File: rtl/instr_seq.sv
// instr_seq: instruction fetch/decode sequencer driving memory, register and PC strobes
module instr_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] MDB_out,
  input  logic        mem_rdy,
  output logic [15:0] IR,
  output logic [3:0]  state,
  output logic [2:0]  MAB_sel,
  output logic        mem_rd,
  output logic        MW,
  output logic        RW,
  output logic        PC_inc,
  output logic        src_ext_ld,
  output logic        dst_ext_ld,
  output logic        inc_en,
  output logic        inc_two,
  output logic        jmp_eval,
  output logic        illegal,
  output logic        instr_done
);
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    SRC_EXT = 4'd2,
    SRC_RD  = 4'd3,
    SRC_INC = 4'd4,
    DST_EXT = 4'd5,
    DST_RD  = 4'd6,
    EXEC    = 4'd7,
    DST_WR  = 4'd8
  } state_t;
  state_t cur, nxt, dst_ph;
  logic [3:0] op, sr;
  logic [1:0] am;
  logic jmp, fmt1, fmt2, bad, cg, imm, ad, cmp_bit, reg_dst, mem_dst, src_ext, src_rd;
  logic [2:0] sel;
  logic rd, mw, rw, pci, sxl, dxl, ien, itw, jev, ill, done;
  assign op      = IR[15:12];
  assign jmp     = IR[15:13] == 3'b001;
  assign fmt2    = op == 4'b0001 && !IR[9];
  assign fmt1    = IR[15] | IR[14];
  assign bad     = !(jmp | fmt1 | fmt2);
  assign am      = IR[5:4];
  assign sr      = fmt1 ? IR[11:8] : IR[3:0];
  assign ad      = fmt1 & IR[7];
  assign cg      = sr == 4'd3 || (sr == 4'd2 && am[1]);
  assign imm     = am == 2'd3 && sr == 4'd0;
  assign src_ext = (am == 2'd1 && sr != 4'd3) || imm;
  assign src_rd  = am[1] && !cg && !imm;
  assign cmp_bit = op == 4'b1001 || op == 4'b1011;
  assign reg_dst = (fmt1 && !ad) || (fmt2 && am == 2'd0);
  assign mem_dst = (ad && !cmp_bit) || (fmt2 && am != 2'd0);
  assign dst_ph  = ad ? DST_EXT : EXEC;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cur <= FETCH;
      IR  <= '0;
    end else begin
      cur <= nxt;
      if (cur == FETCH && mem_rdy) IR <= MDB_out;
    end
  always_comb begin
    nxt  = cur;
    sel  = 3'd0;
    rd   = 1'b0;
    mw   = 1'b0;
    rw   = 1'b0;
    pci  = 1'b0;
    sxl  = 1'b0;
    dxl  = 1'b0;
    ien  = 1'b0;
    itw  = 1'b0;
    jev  = 1'b0;
    ill  = 1'b0;
    done = 1'b0;
    case (cur)
      FETCH: begin
        rd = 1'b1;
        if (mem_rdy) begin
          pci = 1'b1;
          nxt = DECODE;
        end
      end
      DECODE: begin
        ill  = bad;
        done = bad;
        nxt  = bad ? FETCH : jmp ? EXEC : src_ext ? SRC_EXT : src_rd ? SRC_RD : dst_ph;
      end
      SRC_EXT: begin
        rd = 1'b1;
        if (mem_rdy) begin
          pci = 1'b1;
          sxl = 1'b1;
          nxt = am == 2'd1 ? SRC_RD : dst_ph;
        end
      end
      SRC_RD: begin
        rd  = 1'b1;
        sel = am == 2'd1 ? 3'd2 : 3'd1;
        if (mem_rdy) nxt = am == 2'd3 ? SRC_INC : dst_ph;
      end
      SRC_INC: begin
        ien = 1'b1;
        rw  = 1'b1;
        itw = !IR[6];
        nxt = dst_ph;
      end
      DST_EXT: begin
        rd = 1'b1;
        if (mem_rdy) begin
          pci = 1'b1;
          dxl = 1'b1;
          nxt = op == 4'b0100 ? EXEC : DST_RD;
        end
      end
      DST_RD: begin
        rd  = 1'b1;
        sel = 3'd2;
        if (mem_rdy) nxt = EXEC;
      end
      EXEC: begin
        jev  = jmp;
        rw   = reg_dst && !cmp_bit;
        done = !mem_dst;
        nxt  = mem_dst ? DST_WR : FETCH;
      end
      DST_WR: begin
        mw  = 1'b1;
        sel = (fmt1 || am == 2'd1) ? 3'd2 : 3'd1;
        if (mem_rdy) begin
          done = 1'b1;
          nxt  = FETCH;
        end
      end
      default: nxt = FETCH;
    endcase
  end
  assign state = cur;
  assign {MAB_sel, mem_rd, MW, RW, PC_inc, src_ext_ld, dst_ext_ld, inc_en, inc_two, jmp_eval, illegal, instr_done} =
    rst_n ? {sel, rd, mw, rw, pci, sxl, dxl, ien, itw, jev, ill, done} : 14'd0;
endmodule

// File: tb/tb_instr_seq.sv
// tb_instr_seq: randomized and directed checking of instr_seq against a step-script model
module tb_instr_seq;
  logic clk = 1'b0;
  logic rst_n;
  logic [15:0] MDB_out;
  logic mem_rdy;
  logic [15:0] IR;
  logic [3:0] state;
  logic [2:0] MAB_sel;
  logic mem_rd, MW, RW, PC_inc, src_ext_ld, dst_ext_ld, inc_en, inc_two, jmp_eval, illegal, instr_done;
  logic [17:0] outs;
  int tests = 0;
  int fails = 0;
  instr_seq dut (
    .clk(clk), .rst_n(rst_n), .MDB_out(MDB_out), .mem_rdy(mem_rdy), .IR(IR), .state(state),
    .MAB_sel(MAB_sel), .mem_rd(mem_rd), .MW(MW), .RW(RW), .PC_inc(PC_inc), .src_ext_ld(src_ext_ld),
    .dst_ext_ld(dst_ext_ld), .inc_en(inc_en), .inc_two(inc_two), .jmp_eval(jmp_eval),
    .illegal(illegal), .instr_done(instr_done)
  );
  always #5 clk = ~clk;
  assign outs = {state, MAB_sel, mem_rd, MW, RW, PC_inc, src_ext_ld, dst_ext_ld, inc_en, inc_two, jmp_eval, illegal, instr_done};
  typedef struct packed {
    logic [3:0] st;
    logic [2:0] sel;
    logic mem, rd, mw, rw, ien, itw, jev, ill, pci, sxl, dxl, done;
  } step_t;
  step_t exp_q[$];
  logic [15:0] exp_ir;
  logic [63:0] trace_w, model_w;
  int trace_n, pc_cnt, pc_at, sxl_cnt, mw_cnt, jev_cnt, ill_cnt, done_at;
  logic [2:0] mw_sel;
  logic itw_v;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask
  function automatic step_t mk(input logic [3:0] st);
    step_t s;
    s = '0;
    s.st = st;
    s.mem = st inside {4'd0, 4'd2, 4'd3, 4'd5, 4'd6, 4'd8};
    s.rd = s.mem && st != 4'd8;
    return s;
  endfunction
  task automatic build(input logic [15:0] w);
    step_t s;
    logic jmp, f1, f2, cg, imm, ad, cmpbit, regd, memd;
    logic [1:0] am;
    logic [3:0] sr, op;
    op = w[15:12];
    jmp = w[15:13] == 3'b001;
    f2 = op == 4'd1 && w[9:7] < 3'd4;
    f1 = op >= 4'd4;
    am = w[5:4];
    sr = f1 ? w[11:8] : w[3:0];
    ad = f1 && w[7];
    cg = sr == 4'd3 || (sr == 4'd2 && am >= 2'd2);
    imm = am == 2'd3 && sr == 4'd0;
    cmpbit = op == 4'd9 || op == 4'd11;
    s = mk(4'd0); s.pci = 1'b1; exp_q.push_back(s);
    s = mk(4'd1);
    if (!(jmp || f1 || f2)) begin
      s.ill = 1'b1; s.done = 1'b1; exp_q.push_back(s);
    end else begin
      exp_q.push_back(s);
      if (!jmp) begin
        if ((am == 2'd1 && sr != 4'd3) || imm) begin
          s = mk(4'd2); s.pci = 1'b1; s.sxl = 1'b1; exp_q.push_back(s);
          if (am == 2'd1) begin s = mk(4'd3); s.sel = 3'd2; exp_q.push_back(s); end
        end else if (am >= 2'd2 && !cg) begin
          s = mk(4'd3); s.sel = 3'd1; exp_q.push_back(s);
          if (am == 2'd3) begin
            s = mk(4'd4); s.rw = 1'b1; s.ien = 1'b1; s.itw = !w[6]; exp_q.push_back(s);
          end
        end
        if (ad) begin
          s = mk(4'd5); s.pci = 1'b1; s.dxl = 1'b1; exp_q.push_back(s);
          if (op != 4'd4) begin s = mk(4'd6); s.sel = 3'd2; exp_q.push_back(s); end
        end
      end
      memd = (ad && !cmpbit) || (f2 && am != 2'd0);
      regd = (f1 && !ad) || (f2 && am == 2'd0);
      s = mk(4'd7); s.jev = jmp; s.rw = regd && !cmpbit; s.done = !memd; exp_q.push_back(s);
      if (memd) begin
        s = mk(4'd8); s.mw = 1'b1; s.sel = (f1 || am == 2'd1) ? 3'd2 : 3'd1; s.done = 1'b1; exp_q.push_back(s);
      end
    end
  endtask
  always @(negedge clk) begin
    step_t s;
    logic fin;
    if (!rst_n) exp_ir = 16'h0;
    else if (exp_q.size() > 0) begin
      s = exp_q[0];
      fin = !s.mem || mem_rdy;
      chk("cycle_outputs", outs, {s.st, s.sel, s.rd, s.mw, s.rw, s.pci & fin, s.sxl & fin, s.dxl & fin,
                                  s.ien, s.itw, s.jev, s.ill, s.done & fin});
      chk("IR", IR, exp_ir);
      trace_w = (trace_w << 4) | 64'(state);
      trace_n++;
      pc_cnt += int'(PC_inc);
      if (PC_inc) pc_at = trace_n;
      sxl_cnt += int'(src_ext_ld);
      mw_cnt += int'(MW);
      if (MW) mw_sel = MAB_sel;
      if (state == 4'd4) itw_v = inc_two;
      jev_cnt += int'(jmp_eval);
      ill_cnt += int'(illegal);
      if (instr_done) done_at = trace_n;
      if (fin) begin
        if (s.st == 4'd0) exp_ir = MDB_out;
        void'(exp_q.pop_front());
      end
    end
  end
  task automatic start(input logic [15:0] w);
    build(w);
    model_w = 0;
    foreach (exp_q[i]) model_w = (model_w << 4) | 64'(exp_q[i].st);
    MDB_out = w;
    trace_w = 0; trace_n = 0; pc_cnt = 0; pc_at = 0; sxl_cnt = 0; mw_cnt = 0;
    jev_cnt = 0; ill_cnt = 0; done_at = 0; mw_sel = 3'd0; itw_v = 1'bx;
  endtask
  task automatic run_instr(input logic [15:0] w, input int stall, input bit rnd);
    int n;
    start(w);
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      mem_rdy = (n < stall) ? 1'b0 : rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() > 0) begin
      chk("timeout", 64'(exp_q.size()), 0);
      exp_q.delete();
    end
  endtask
  initial begin
    logic [15:0] w;
    int n;
    rst_n = 1'b0;
    mem_rdy = 1'b1;
    MDB_out = 16'h1234;
    #3;
    chk("reset_outs", outs, 0);
    chk("reset_ir", IR, 0);
    repeat (2) @(negedge clk);
    chk("reset_outs_clocked", outs, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_instr(16'h4405, 0, 0);
    chk("mov_rr_model", model_w, 64'h017);
    chk("mov_rr_trace", trace_w, 64'h017);
    chk("mov_rr_len", trace_n, 3);
    chk("mov_rr_pc", pc_cnt, 1);
    chk("mov_rr_done_at", done_at, 3);
    run_instr(16'h4035, 0, 0);
    chk("mov_imm_model", model_w, 64'h0127);
    chk("mov_imm_trace", trace_w, 64'h0127);
    chk("mov_imm_len", trace_n, 4);
    chk("mov_imm_pc", pc_cnt, 2);
    chk("mov_imm_sxl", sxl_cnt, 1);
    run_instr(16'h5496, 0, 0);
    chk("add_idx_model", model_w, 64'h01235678);
    chk("add_idx_trace", trace_w, 64'h01235678);
    chk("add_idx_len", trace_n, 8);
    chk("add_idx_pc", pc_cnt, 3);
    chk("add_idx_mw", mw_cnt, 1);
    chk("add_idx_mw_sel", mw_sel, 2);
    run_instr(16'h4435, 0, 0);
    chk("mov_ai_model", model_w, 64'h01347);
    chk("mov_ai_trace", trace_w, 64'h01347);
    chk("mov_ai_inc_two", itw_v, 1);
    run_instr(16'h4475, 0, 0);
    chk("movb_ai_trace", trace_w, 64'h01347);
    chk("movb_ai_inc_two", itw_v, 0);
    run_instr(16'h3C05, 3, 0);
    chk("jmp_stall_trace", trace_w, 64'h000017);
    chk("jmp_stall_len", trace_n, 6);
    chk("jmp_stall_pc_at", pc_at, 4);
    chk("jmp_stall_pc", pc_cnt, 1);
    chk("jmp_eval", jev_cnt, 1);
    run_instr(16'h0000, 0, 0);
    chk("illegal_trace", trace_w, 64'h01);
    chk("illegal_len", trace_n, 2);
    chk("illegal_pulse", ill_cnt, 1);
    start(16'h5496);
    mem_rdy = 1'b1;
    n = 0;
    while (state != 4'd6 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reach_dst_rd", state, 6);
    mem_rdy = 1'b0;
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_state", state, 0);
    chk("abort_ir", IR, 0);
    chk("abort_outs", outs, 0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_outs_clocked", outs, 0);
    end
    chk("abort_no_mw", mw_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_instr(16'h4405, 0, 0);
    chk("resume_trace", trace_w, 64'h017);
    chk("resume_pc", pc_cnt, 1);
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: w = {3'b001, 13'($urandom)};
        1: w = {4'b0001, 2'($urandom), 1'b0, 9'($urandom)};
        2: w = {4'($urandom_range(4, 15)), 12'($urandom)};
        default: w = 16'($urandom);
      endcase
      run_instr(w, 0, 1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/instr_seq.md
INSTR_SEQ -- requirements
Module: instr_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes occur on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port MDB_out, input, 16 bits: memory data bus read word.
REQ-004 SHALL have port mem_rdy, input, 1 bit: memory completes the current access when sampled high at a rising clock edge.
REQ-005 SHALL have port IR, output, 16 bits: latched instruction word.
REQ-006 SHALL have port state, output, 4 bits: current FSM state code (see REQ-011).
REQ-007 SHALL have port MAB_sel, output, 3 bits: address source select; 0 = PC, 1 = Sout, 2 = CALC.
REQ-008 SHALL have these strobe outputs, 1 bit each: mem_rd (memory read), MW (memory write), RW (register write), PC_inc, src_ext_ld, dst_ext_ld, inc_en, inc_two, jmp_eval, illegal, instr_done.

Function
REQ-009 SHALL decode the instruction format from IR:
- Jump: IR[15:13] = 001.
- Format II: IR[15:12] = 0001 with IR[9:7] in {RRC 000, SWPB 001, RRA 010, SXT 011}.
- Format I: IR[15:12] >= 0100.
- All other encodings, including PUSH, CALL and RETI, are illegal.
REQ-010 SHALL take the operand fields from IR:
- As = IR[5:4]; Ad = IR[7] (Format I only).
- SR = IR[11:8] (Format I) or IR[3:0] (Format II); BW = IR[6].
- Constant generator (CG) = (SR = 3) or (SR = 2 and As >= 2).
REQ-011 SHALL implement these states: FETCH 0, DECODE 1, SRC_EXT 2, SRC_RD 3, SRC_INC 4, DST_EXT 5, DST_RD 6, EXEC 7, DST_WR 8.
REQ-012 Memory states FETCH, SRC_EXT, SRC_RD, DST_EXT, DST_RD and DST_WR SHALL hold until mem_rdy = 1; every other state SHALL last exactly one cycle.
REQ-013 FETCH SHALL behave as follows:
- Drive MAB_sel = 0 and mem_rd = 1.
- On completion, load IR <= MDB_out, pulse PC_inc, then go to DECODE.
REQ-014 DECODE SHALL choose the next state by this priority:
- Illegal: pulse illegal and instr_done, then go to FETCH.
- Jump: go to EXEC.
- Source extension needed (As = 01 and SR != 3, or As = 11 and SR = 0): go to SRC_EXT.
- Source memory read needed (As >= 10, not CG, not immediate): go to SRC_RD.
- Otherwise: go to the destination phase (REQ-018).
REQ-015 SRC_EXT SHALL drive MAB_sel = 0 and mem_rd = 1. On completion it pulses PC_inc and src_ext_ld, then goes to SRC_RD if As = 01, else to the destination phase.
REQ-016 SRC_RD SHALL drive mem_rd = 1, with MAB_sel = 2 when As = 01 and MAB_sel = 1 otherwise. On completion it goes to SRC_INC if As = 11, else to the destination phase.
REQ-017 SRC_INC SHALL assert inc_en = 1, RW = 1 and inc_two = ~BW, then go to the destination phase.
REQ-018 The destination phase SHALL be entered as follows:
- Format I with Ad = 1: DST_EXT.
- Otherwise: EXEC.
REQ-019 DST_EXT SHALL drive MAB_sel = 0 and mem_rd = 1. On completion it pulses PC_inc and dst_ext_ld, then goes to DST_RD, or straight to EXEC for MOV (IR[15:12] = 0100).
REQ-020 DST_RD SHALL drive MAB_sel = 2 and mem_rd = 1, then go to EXEC.
REQ-021 EXEC SHALL behave as follows:
- Jump: pulse jmp_eval.
- Register destination (Format I with Ad = 0, or Format II with As = 00): assert RW = 1, except for CMP (1001) and BIT (1011).
- Memory destination (Format I with Ad = 1 and not CMP/BIT, or Format II with As != 00): go to DST_WR.
- Otherwise: pulse instr_done and go to FETCH.
REQ-022 DST_WR SHALL behave as follows:
- Drive MW = 1 and mem_rd = 0.
- Address: MAB_sel = 2 for Format I or As = 01; MAB_sel = 1 otherwise.
- On completion, pulse instr_done and go to FETCH.
REQ-023 All strobes SHALL be zero in any state or cycle not listed above. mem_rd and MW SHALL never both be 1. PC_inc SHALL assert at most once per completed memory access.
REQ-024 When mem_rdy is low, the FSM SHALL hold its state and outputs, with no PC_inc and no ld pulses.

Reset
REQ-025 While rst_n = 0, the block SHALL force state = FETCH, IR = 0, MAB_sel = 0, and all strobes including mem_rd to 0, regardless of clk.
REQ-026 FETCH SHALL assert mem_rd in the first cycle after rst_n rises.
REQ-027 Reset asserted in any state, including mid-wait, SHALL abort the instruction with no MW, RW or PC_inc pulse.

Verification
REQ-028 The bench SHALL cover at least these scenarios (mem_rdy = 1 unless stated):
- 0x4405 (MOV R4,R5) -> FETCH, DECODE, EXEC; RW = 1 in EXEC; one PC_inc; instr_done after 3 cycles.
- 0x4035 + 0x1234 (MOV #0x1234,R5) -> FETCH, DECODE, SRC_EXT, EXEC; two PC_inc; src_ext_ld once.
- 0x5496 (ADD 2(R4),4(R6)) -> FETCH, DECODE, SRC_EXT, SRC_RD, DST_EXT, DST_RD, EXEC, DST_WR; three PC_inc; MW with MAB_sel = 2.
- 0x4435 / 0x4475 (MOV(.B) @R4+,R5) -> SRC_RD then SRC_INC; inc_two = 1 / 0 respectively.
- mem_rdy low for 3 cycles in FETCH -> state stays 0, no PC_inc until the 4th cycle; then 0x3C05 -> jmp_eval one cycle; 0x0000 -> illegal pulse, back to FETCH.
- rst_n low during DST_RD -> state 0, IR 0, no MW; FETCH resumes after release.
